// File: rtl/data_ram_wbuf_if.sv
// data_ram_wbuf_if: memory-stage request/response bus for the data RAM.
interface data_ram_wbuf_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        addr_err_o;
  logic        stallreq_o;
  modport master (output ce, we, addr, sel, data_i, input data_o, addr_err_o, stallreq_o);
  modport slave  (input ce, we, addr, sel, data_i, output data_o, addr_err_o, stallreq_o);
endinterface

// File: rtl/data_ram_wbuf.sv
// data_ram_wbuf: data RAM with one-entry posted write buffer and per-lane load forwarding.
// Optional power-up clear engine enabled by `define DATA_RAM_CLEAR_EN.
module data_ram_wbuf #(
  parameter int DEPTH_LOG2 = 12
) (
  input logic           clk,
  input logic           rst,
  data_ram_wbuf_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [31:0]           mem [DEPTH];
  logic                  wb_v;
  logic [DEPTH_LOG2-1:0] wb_idx;
  logic [3:0]            wb_sel;
  logic [31:0]           wb_data;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  oor, stall, acc, hit, commit, ld, clr;
  logic [DEPTH_LOG2-1:0] clr_idx;
  logic [31:0]           smask, fmask;
`ifdef DATA_RAM_CLEAR_EN
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t                state;
  logic [DEPTH_LOG2-1:0] clr_cnt;
  logic                  stall_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      stall_q <= 1'b1;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (&clr_cnt) begin
        state   <= IDLE;
        stall_q <= 1'b0;
      end
    end
  assign stall   = stall_q;
  assign clr     = state == CLEAR;
  assign clr_idx = clr_cnt;
`else
  assign stall   = 1'b0;
  assign clr     = 1'b0;
  assign clr_idx = '0;
`endif
  assign idx    = bus.addr[DEPTH_LOG2+1:2];
  assign oor    = |bus.addr[31:DEPTH_LOG2+2];
  assign smask  = {{8{bus.sel[3]}}, {8{bus.sel[2]}}, {8{bus.sel[1]}}, {8{bus.sel[0]}}};
  assign acc    = bus.ce & bus.we & !oor & |bus.sel & !stall;
  assign hit    = wb_v && wb_idx == idx;
  // Old entry leaves the buffer unless this store merges into it
  assign commit = wb_v & !(acc & hit);
  assign ld     = rst & bus.ce & !bus.we & !oor & !stall;
  assign fmask  = hit ? {{8{wb_sel[3]}}, {8{wb_sel[2]}}, {8{wb_sel[1]}}, {8{wb_sel[0]}}} : '0;
  assign bus.data_o     = ld ? (mem[idx] & ~fmask) | (wb_data & fmask) : '0;
  assign bus.addr_err_o = rst & bus.ce & oor;
  assign bus.stallreq_o = stall;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wb_v    <= 1'b0;
      wb_idx  <= '0;
      wb_sel  <= '0;
      wb_data <= '0;
    end else if (acc && hit) begin
      wb_sel  <= wb_sel | bus.sel;
      wb_data <= (wb_data & ~smask) | (bus.data_i & smask);
    end else if (acc) begin
      wb_v    <= 1'b1;
      wb_idx  <= idx;
      wb_sel  <= bus.sel;
      wb_data <= bus.data_i & smask;
    end else
      wb_v <= 1'b0;
  always_ff @(posedge clk)
    if (clr)
      mem[clr_idx] <= '0;
    else if (commit)
      for (int k = 0; k < 4; k++)
        if (wb_sel[k]) mem[wb_idx][8*k+:8] <= wb_data[8*k+:8];
endmodule

// File: doc/data_ram_wbuf.md
# data_ram_wbuf

Data-side memory responder for the load/store path: it answers the memory stage's `ce/we/addr/sel/data` requests with byte-lane writes and full-word reads. A one-entry posted write buffer retires each store one cycle later. Loads see buffered bytes through per-lane forwarding, so store→load sequences are coherent. An optional power-up clear engine zeroes the array and holds the pipeline through `stallreq_o`.

## Interface
- `DEPTH_LOG2`, default 12: word-array depth is 2^DEPTH_LOG2 words.
- `clk` input 1: sole clock, all state on rising edge.
- `rst` input 1: asynchronous, active-low reset (asserted at 0).
- `ce` input 1: request valid (chip enable).
- `we` input 1: 1 = store, 0 = load.
- `addr` input 32: byte address; word index = `addr[DEPTH_LOG2+1:2]`; `addr[1:0]` ignored (lanes given by `sel`).
- `sel` input 4: byte lanes, big-endian: `sel[3]`↔`[31:24]` (offset 0) … `sel[0]`↔`[7:0]` (offset 3).
- `data_i` input 32: store data, lane-aligned.
- `data_o` output 32: load data, full word, combinational.
- `addr_err_o` output 1: `ce` with `addr[31:DEPTH_LOG2+2]` ≠ 0, combinational.
- `stallreq_o` output 1: block cannot accept requests.

## Operation
- Storage: array `mem[0:2^DEPTH_LOG2-1]` of 32 bits; write buffer `{wb_v, wb_idx, wb_sel, wb_data}`.
- Store accepted when `ce & we & !addr_err_o & sel≠0 & !stallreq_o`. A store with `sel=0` or out of range is a no-op.
- On an accepted store edge:
  - Buffer empty: load buffer with `{1, idx, sel, data_i & lane mask}`.
  - Buffer valid, `wb_idx==idx`: merge. Lanes in `sel` overwrite buffer lanes; `wb_sel |= sel`. No array write.
  - Buffer valid, different idx: commit old entry to `mem[wb_idx]` (only `wb_sel` lanes), then load the new entry the same edge.
- No accepted store and `wb_v`: commit (drain) and clear `wb_v`.
- Load (`ce & !we`, in range, not stalled): `data_o` = `mem[idx]`, with each lane k replaced by `wb_data` lane k when `wb_v & wb_idx==idx & wb_sel[k]`. `sel` does not mask load data.
- `data_o = 0` when `ce=0`, `we=1`, out of range, stalled, or in reset.
- `addr_err_o` is asserted regardless of `we`. It is 0 when `ce=0` or in reset.

## Timing
- Load latency 0: combinational same-cycle data, as the memory stage requires.
- Store visible to a load in the very next cycle via forwarding. It reaches the array 1 cycle after the store, or on the next store to another word.
- Reset (async, `rst=0`) effects:
  - Clears `wb_v` immediately, with no drain.
  - A pending buffered store is lost; this is accepted.
  - `data_o=0`, `addr_err_o=0`.
  - `stallreq_o` is 1 with the clear engine compiled in, else 0.
- Back-to-back stores to the same word merge indefinitely; the buffer drains on the first non-store cycle.

## Configuration
- Macro `DATA_RAM_CLEAR_EN`.
- Defined:
  - FSM states `CLEAR`, `IDLE`. Reset enters `CLEAR` with counter `clr_cnt=0`.
  - In `CLEAR`, each cycle writes `mem[clr_cnt]=0` and increments the counter, with `stallreq_o=1` and requests ignored.
  - At `clr_cnt==2^DEPTH_LOG2-1` the state moves to `IDLE` after that write. Total 2^DEPTH_LOG2 cycles after `rst` deasserts.
  - `stallreq_o=0` from the first `IDLE` cycle. Reset mid-clear restarts at 0.
- Undefined: no FSM or counter. `stallreq_o` is tied 0. Array contents are uninitialized after reset. Requests are accepted from the first edge after `rst` rises.

## Test plan
- Clear: macro on, `DEPTH_LOG2=4` → after reset release, `stallreq_o=1` for exactly 16 cycles, then 0; load of every word returns `0x00000000`.
- Byte store/forward: SW `0x11223344` to 0x10, next cycle SB `sel=0100`, `data_i=0x00AA0000` to 0x11, next cycle LW 0x10 → `0x11AA3344`. Later, after an idle cycle, LW returns the same value from the array.
- Buffer commit on different word: SW `0xDEADBEEF` to 0x0, then SW `0xCAFEF00D` to 0x4 in consecutive cycles, then LW 0x0 → `0xDEADBEEF`, LW 0x4 → `0xCAFEF00D`.
- Out of range (`DEPTH_LOG2=4`): SW to 0x40 → `addr_err_o=1` that cycle; a following LW 0x0 is unchanged; LW 0x40 → `data_o=0`, `addr_err_o=1`.
- `sel=0000` store to 0x8 → no change, LW 0x8 returns its prior value. A `ce=0` cycle gives `data_o=0`.
- Reset mid-operation: SW `0x12345678` to 0x20, assert `rst` low before the next edge → `wb_v=0`, `data_o=0` immediately. With the macro on, the clear restarts and LW 0x20 afterwards → `0`.
